// File: rtl/core_alu_seq_pkg.sv
// Shared ALU defines: func codes, FSM encoding, default XLEN.
// Build option CORE_ALU_MULDIV_EN enables the M-extension unit.
`ifndef ALUFuncW
`define ALUFuncW 5
`endif

package core_alu_seq_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [`ALUFuncW-1:0] ALUFunc_ADD    = 5'd0;
  localparam logic [`ALUFuncW-1:0] ALUFunc_SUB    = 5'd1;
  localparam logic [`ALUFuncW-1:0] ALUFunc_XOR    = 5'd2;
  localparam logic [`ALUFuncW-1:0] ALUFunc_OR     = 5'd3;
  localparam logic [`ALUFuncW-1:0] ALUFunc_AND    = 5'd4;
  localparam logic [`ALUFuncW-1:0] ALUFunc_SLL    = 5'd5;
  localparam logic [`ALUFuncW-1:0] ALUFunc_SRL    = 5'd6;
  localparam logic [`ALUFuncW-1:0] ALUFunc_SRA    = 5'd7;
  localparam logic [`ALUFuncW-1:0] ALUFunc_SLT    = 5'd8;
  localparam logic [`ALUFuncW-1:0] ALUFunc_SLTU   = 5'd9;
  localparam logic [`ALUFuncW-1:0] ALUFunc_MUL    = 5'd10;
  localparam logic [`ALUFuncW-1:0] ALUFunc_MULH   = 5'd11;
  localparam logic [`ALUFuncW-1:0] ALUFunc_MULHSU = 5'd12;
  localparam logic [`ALUFuncW-1:0] ALUFunc_MULHU  = 5'd13;
  localparam logic [`ALUFuncW-1:0] ALUFunc_DIV    = 5'd14;
  localparam logic [`ALUFuncW-1:0] ALUFunc_DIVU   = 5'd15;
  localparam logic [`ALUFuncW-1:0] ALUFunc_REM    = 5'd16;
  localparam logic [`ALUFuncW-1:0] ALUFunc_REMU   = 5'd17;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_muldiv(
    input logic [`ALUFuncW-1:0] f
  );
    return (f >= ALUFunc_MUL) &&
           (f <= ALUFunc_REMU);
  endfunction

endpackage

// File: rtl/core_alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider.
// Instantiated only when CORE_ALU_MULDIV_EN is defined.
module core_alu_muldiv
  import core_alu_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 start,
  input  logic [`ALUFuncW-1:0] func,
  input  logic [XLEN-1:0]      a,
  input  logic [XLEN-1:0]      b,
  output logic                 fast,
  output logic [XLEN-1:0]      fast_res,
  output logic                 busy,
  output logic                 done,
  output logic [XLEN-1:0]      res
);

  localparam int CW = $clog2(XLEN + 1);

  logic            run;
  logic [CW-1:0]   cnt;
  logic [2*XLEN-1:0] p;
  logic [XLEN-1:0] md;
  logic            div_q;
  logic            hi;
  logic            rem_sel;
  logic            neg_q;
  logic            neg_r;

  logic            sgn_a, sgn_b, sa, sb;
  logic            div_op, by_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   add_sum, rs, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] q, r;

  // Operand decode, magnitudes and fast-path detection
  always_comb begin
    sgn_a = (func == ALUFunc_MULH) || (func == ALUFunc_MULHSU) ||
            (func == ALUFunc_DIV) || (func == ALUFunc_REM);
    sgn_b = (func == ALUFunc_MULH) ||
            (func == ALUFunc_DIV) || (func == ALUFunc_REM);
    sa = sgn_a & a[XLEN-1];
    sb = sgn_b & b[XLEN-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    div_op = (func >= ALUFunc_DIV) && (func <= ALUFunc_REMU);
    by_zero = div_op && (b == '0);
    ovf = ((func == ALUFunc_DIV) || (func == ALUFunc_REM)) &&
          (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    fast = by_zero || ovf;
    fast_res = '0;
    if (by_zero)
      fast_res = ((func == ALUFunc_DIV) || (func == ALUFunc_DIVU)) ?
                 '1 : a;
    else if (ovf)
      fast_res = (func == ALUFunc_DIV) ? a : '0;
  end

  // One iteration step and the final sign fixup
  always_comb begin
    add_sum = {1'b0, p[2*XLEN-1:XLEN]} +
              (p[0] ? {1'b0, md} : {(XLEN+1){1'b0}});
    rs = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    diff = rs - {1'b0, md};
    prod = neg_q ? -p : p;
    q = neg_q ? -p[XLEN-1:0] : p[XLEN-1:0];
    r = neg_r ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    if (div_q)
      res = rem_sel ? r : q;
    else
      res = hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  assign busy = run;
  assign done = run && (cnt == CW'(XLEN));

  // Operand latch, iteration counter and partial result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      cnt     <= '0;
      p       <= '0;
      md      <= '0;
      div_q   <= 1'b0;
      hi      <= 1'b0;
      rem_sel <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (flush) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run     <= 1'b1;
      cnt     <= '0;
      p       <= {{XLEN{1'b0}}, div_op ? mag_a : mag_b};
      md      <= div_op ? mag_b : mag_a;
      div_q   <= div_op;
      hi      <= (func != ALUFunc_MUL);
      rem_sel <= (func == ALUFunc_REM) || (func == ALUFunc_REMU);
      neg_q   <= sa ^ sb;
      neg_r   <= sa;
    end else if (done) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (div_q) begin
        if (!diff[XLEN])
          p <= {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
        else
          p <= {rs[XLEN-1:0], p[XLEN-2:0], 1'b0};
      end else begin
        p <= {add_sum, p[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/core_alu_seq.sv
// Handshaked RV32I/RV64I ALU with registered result.
// Define CORE_ALU_MULDIV_EN to add the iterative M-extension unit.
module core_alu_seq
  import core_alu_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_in,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic [`ALUFuncW-1:0] func_in,
  input  logic [XLEN-1:0]      opnum1_in,
  input  logic [XLEN-1:0]      opnum2_in,
  output logic                 resp_valid_out,
  input  logic                 resp_ready_in,
  output logic [XLEN-1:0]      res_out
);

  localparam int SHAMT_W = $clog2(XLEN);

  logic [1:0]         state;
  logic [XLEN-1:0]    res_q;
  logic               accept;
  logic               launch_busy;
  logic [XLEN-1:0]    launch_res;
  logic [XLEN-1:0]    alu_res;
  logic [SHAMT_W-1:0] shamt;

  assign req_ready_out = (state == ST_IDLE) ||
                         ((state == ST_DONE) && resp_ready_in);
  assign resp_valid_out = (state == ST_DONE);
  assign res_out = res_q;
  assign accept = req_valid_in && req_ready_out && !flush_in;

  // Single-cycle RV32I/RV64I datapath
  always_comb begin
    alu_res = '0;
    shamt = opnum2_in[SHAMT_W-1:0];
    unique case (1'b1)
      (func_in == ALUFunc_ADD):  alu_res = opnum1_in + opnum2_in;
      (func_in == ALUFunc_SUB):  alu_res = opnum1_in - opnum2_in;
      (func_in == ALUFunc_XOR):  alu_res = opnum1_in ^ opnum2_in;
      (func_in == ALUFunc_OR):   alu_res = opnum1_in | opnum2_in;
      (func_in == ALUFunc_AND):  alu_res = opnum1_in & opnum2_in;
      (func_in == ALUFunc_SLL):  alu_res = opnum1_in << shamt;
      (func_in == ALUFunc_SRL):  alu_res = opnum1_in >> shamt;
      (func_in == ALUFunc_SRA):
        alu_res = $signed(opnum1_in) >>> shamt;
      (func_in == ALUFunc_SLT):
        alu_res = {{(XLEN-1){1'b0}},
                   $signed(opnum1_in) < $signed(opnum2_in)};
      (func_in == ALUFunc_SLTU):
        alu_res = {{(XLEN-1){1'b0}}, opnum1_in < opnum2_in};
      default: alu_res = '0;
    endcase
  end

`ifdef CORE_ALU_MULDIV_EN
  logic            md_fast;
  logic [XLEN-1:0] md_fast_res;
  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] md_res;
  logic            is_m;

  assign is_m = is_muldiv(func_in);
  assign launch_busy = is_m && !md_fast;
  assign launch_res = is_m ? md_fast_res : alu_res;

  core_alu_muldiv #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush_in),
    .start    (accept && launch_busy),
    .func     (func_in),
    .a        (opnum1_in),
    .b        (opnum2_in),
    .fast     (md_fast),
    .fast_res (md_fast_res),
    .busy     (md_busy),
    .done     (md_done),
    .res      (md_res)
  );
`else
  assign launch_busy = 1'b0;
  assign launch_res = alu_res;
`endif

  // Handshake FSM and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      res_q <= '0;
    end else if (flush_in) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= launch_busy ? ST_BUSY : ST_DONE;
            if (!launch_busy) res_q <= launch_res;
          end
        end
`ifdef CORE_ALU_MULDIV_EN
        ST_BUSY: begin
          if (md_done) begin
            state <= ST_DONE;
            res_q <= md_res;
          end else if (!md_busy) begin
            state <= ST_IDLE;
          end
        end
`endif
        ST_DONE: begin
          if (resp_ready_in) begin
            if (accept) begin
              state <= launch_busy ? ST_BUSY : ST_DONE;
              if (!launch_busy) res_q <= launch_res;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_alu_seq.sv
// Directed-vector bench for core_alu_seq (XLEN=32).
// M-extension vectors run when CORE_ALU_MULDIV_EN is defined.
module tb_core_alu_seq;
  import core_alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_in = 1'b0;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic [4:0]  func_in = 5'd0;
  logic [31:0] opnum1_in = 32'h0;
  logic [31:0] opnum2_in = 32'h0;
  logic        resp_valid_out;
  logic        resp_ready_in = 1'b0;
  logic [31:0] res_out;

  int n_vec = 0;
  int n_err = 0;

  core_alu_seq #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_in       (flush_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .func_in        (func_in),
    .opnum1_in      (opnum1_in),
    .opnum2_in      (opnum2_in),
    .resp_valid_out (resp_valid_out),
    .resp_ready_in  (resp_ready_in),
    .res_out        (res_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  // Call at #1 after a posedge with the block idle.
  task automatic run(input logic [4:0] f, input logic [31:0] a,
                     input logic [31:0] b, output logic [31:0] r,
                     output int lat);
    func_in = f;
    opnum1_in = a;
    opnum2_in = b;
    req_valid_in = 1'b1;
    @(posedge clk);
    #1;
    req_valid_in = 1'b0;
    func_in = ALUFunc_AND;
    opnum1_in = ~a;
    opnum2_in = ~b;
    lat = 1;
    while (!resp_valid_out && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = res_out;
    resp_ready_in = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_in = 1'b0;
  endtask

  task automatic vec(input string tag, input logic [4:0] f,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e, input int elat);
    logic [31:0] r;
    int lat;
    run(f, a, b, r, lat);
    chk({tag, " res"}, r, e);
    chk({tag, " lat"}, 32'(lat), 32'(elat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst ready", {31'b0, req_ready_out}, 32'd1);
    chk("rst valid", {31'b0, resp_valid_out}, 32'd0);
    chk("rst res", res_out, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    func_in = ALUFunc_DIV;
    opnum1_in = 32'hFFFF_FFF9;
    opnum2_in = 32'd2;
    req_valid_in = 1'b1;
    @(posedge clk);
    #1;
    req_valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst ready", {31'b0, req_ready_out}, 32'd1);
    chk("midrst valid", {31'b0, resp_valid_out}, 32'd0);
    chk("midrst res", res_out, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vec("add", ALUFunc_ADD, 32'd5, 32'd7, 32'd12, 1);

    vec("sra", ALUFunc_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    vec("slt", ALUFunc_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    vec("sltu", ALUFunc_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    vec("sub", ALUFunc_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    vec("xor", ALUFunc_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF,
        32'hFF00_EDCB, 1);
    vec("or", ALUFunc_OR, 32'hA000_0001, 32'h0500_0010,
        32'hA500_0011, 1);
    vec("and", ALUFunc_AND, 32'hFF00_FF00, 32'h0F0F_0F0F,
        32'h0F00_0F00, 1);
    vec("sll", ALUFunc_SLL, 32'd1, 32'd33, 32'd2, 1);
    vec("srl", ALUFunc_SRL, 32'h8000_0000, 32'h1F, 32'd1, 1);
    vec("unk", 5'd31, 32'd3, 32'd4, 32'd0, 1);

    resp_ready_in = 1'b1;
    req_valid_in = 1'b1;
    func_in = ALUFunc_ADD;
    opnum1_in = 32'd1;
    opnum2_in = 32'd2;
    @(posedge clk);
    #1;
    chk("b2b0 valid", {31'b0, resp_valid_out}, 32'd1);
    chk("b2b0 res", res_out, 32'd3);
    func_in = ALUFunc_SUB;
    opnum1_in = 32'd10;
    opnum2_in = 32'd3;
    @(posedge clk);
    #1;
    chk("b2b1 valid", {31'b0, resp_valid_out}, 32'd1);
    chk("b2b1 res", res_out, 32'd7);
    func_in = ALUFunc_ADD;
    opnum1_in = 32'hFFFF_FFFF;
    opnum2_in = 32'd2;
    @(posedge clk);
    #1;
    chk("b2b2 res", res_out, 32'd1);
    resp_ready_in = 1'b0;
    opnum1_in = 32'd100;
    opnum2_in = 32'd100;
    repeat (3) begin
      #1;
      chk("bp ready", {31'b0, req_ready_out}, 32'd0);
      chk("bp valid", {31'b0, resp_valid_out}, 32'd1);
      chk("bp res", res_out, 32'd1);
      @(posedge clk);
      #1;
    end
    req_valid_in = 1'b0;
    resp_ready_in = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_in = 1'b0;
    chk("bp drain", {31'b0, resp_valid_out}, 32'd0);

    func_in = ALUFunc_ADD;
    opnum1_in = 32'd4;
    opnum2_in = 32'd4;
    req_valid_in = 1'b1;
    @(posedge clk);
    #1;
    req_valid_in = 1'b0;
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    chk("flush done", {31'b0, resp_valid_out}, 32'd0);

`ifdef CORE_ALU_MULDIV_EN
    vec("mulh", ALUFunc_MULH, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 34);
    vec("mulhu", ALUFunc_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 34);
    vec("mulhsu", ALUFunc_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 34);
    vec("mul", ALUFunc_MUL, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 34);
    vec("div", ALUFunc_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    vec("rem", ALUFunc_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    vec("divu", ALUFunc_DIVU, 32'd100, 32'd7, 32'd14, 34);
    vec("remu", ALUFunc_REMU, 32'd100, 32'd7, 32'd2, 34);
    vec("divu0", ALUFunc_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    vec("rem0", ALUFunc_REM, 32'd9, 32'd0, 32'd9, 1);
    vec("divovf", ALUFunc_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1);
    vec("removf", ALUFunc_REM, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 1);

    func_in = ALUFunc_MUL;
    opnum1_in = 32'd3;
    opnum2_in = 32'd4;
    req_valid_in = 1'b1;
    @(posedge clk);
    #1;
    req_valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush_in = 1'b1;
    req_valid_in = 1'b1;
    func_in = ALUFunc_ADD;
    opnum1_in = 32'd1;
    opnum2_in = 32'd1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    req_valid_in = 1'b0;
    chk("fl valid", {31'b0, resp_valid_out}, 32'd0);
    chk("fl ready", {31'b0, req_ready_out}, 32'd1);
    vec("fl next", ALUFunc_ADD, 32'd2, 32'd3, 32'd5, 1);
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        @(posedge clk);
        #1;
        seen = seen | resp_valid_out;
      end
      chk("fl stale", {31'b0, seen}, 32'd0);
    end
`else
    vec("mul off", ALUFunc_MUL, 32'd3, 32'd4, 32'd0, 1);
    vec("div off", ALUFunc_DIV, 32'd9, 32'd0, 32'd0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
